// File: rtl/m3_step_period_meter.sv
// ---------------------------------------------------------------------------
// m3_step_period_meter
//
// Receive side of the 3-phase, 12-step commutation sequence. Watches the step
// index (0..11) and its per-step strobe. It measures clocks per step, sums
// each full round of same-direction steps, and reports rotation direction,
// sequence errors and rotor stall to the speed-control loop.
// One clock is 1 us at the 1 MHz system clock.
//
// Ports
//   clkI          in   1      system clock
//   rstI          in   1      synchronous reset, active high
//   m3startI      in   1      motor enable; low forces IDLE and clears outputs
//   stepValidI    in   1      1-cycle strobe: stepI holds a new step index
//   stepI         in   4      step index; 0..11 legal, 12..15 illegal
//   errClrI       in   1      clears sticky seqErrO
//   stepPeriodO   out  CNT_W  clocks between the last two accepted strobes
//   stepPeriodVO  out  1      1-cycle pulse when stepPeriodO updates
//   roundPeriodO  out  ACC_W  sum of the last ROUND_STEPS step periods
//   roundValidO   out  1      1-cycle pulse when roundPeriodO updates
//   dirFwdO       out  1      1 = index incrementing, 0 = decrementing
//   stallO        out  1      high while stalled
//   seqErrO       out  1      sticky: illegal index or non-adjacent step seen
// ---------------------------------------------------------------------------
module m3_step_period_meter #(
  parameter int CNT_W       = 22,
  parameter int ACC_W       = 26,
  parameter int STALL_LIMIT = 4000000,
  parameter int ROUND_STEPS = 12
) (
  input  logic             clkI,
  input  logic             rstI,
  input  logic             m3startI,
  input  logic             stepValidI,
  input  logic [3:0]       stepI,
  input  logic             errClrI,
  output logic [CNT_W-1:0] stepPeriodO,
  output logic             stepPeriodVO,
  output logic [ACC_W-1:0] roundPeriodO,
  output logic             roundValidO,
  output logic             dirFwdO,
  output logic             stallO,
  output logic             seqErrO
);

  localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       ROUND_LAST = 4'(ROUND_STEPS);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    MEASURE,
    STALL
  } stateT;

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [3:0]       roundCnt;
  logic [3:0]       prevStep;

  // Saturating step counter increment; it never wraps past the stall limit.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    if (c >= LIMIT) return LIMIT;
    return c + CNT_ONE;
  endfunction

  // The period is unsigned, so widening into the accumulator is a zero-extend.
  function automatic logic [ACC_W-1:0] zext(input logic [CNT_W-1:0] c);
    return ACC_W'(c);
  endfunction

  logic             legal;
  logic             isFwd;
  logic             isRev;
  logic [3:0]       pNext;
  logic [3:0]       pPrev;
  logic [3:0]       roundNext;
  logic [ACC_W-1:0] accSum;

  always_comb begin
    legal     = (stepI < 4'd12);
    // Neighbours of the previous step with the 11 <-> 0 wrap.
    pNext     = (prevStep == 4'd11) ? 4'd0  : prevStep + 4'd1;
    pPrev     = (prevStep == 4'd0)  ? 4'd11 : prevStep - 4'd1;
    isFwd     = legal && (stepI == pNext);
    isRev     = legal && (stepI == pPrev);
    roundNext = roundCnt + 4'd1;
    accSum    = acc + zext(cnt);
  end

  always_ff @(posedge clkI) begin
    stepPeriodVO <= 1'b0;
    roundValidO  <= 1'b0;
    // Dropping the motor enable behaves exactly like reset, strobes included.
    if (rstI || !m3startI) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      roundCnt     <= '0;
      prevStep     <= '0;
      stepPeriodO  <= '0;
      roundPeriodO <= '0;
      dirFwdO      <= 1'b1;
      stallO       <= 1'b0;
      seqErrO      <= 1'b0;
    end else begin
      // A new error later in this block overrides the clear.
      if (errClrI) seqErrO <= 1'b0;
      case (state)
        IDLE: state <= SYNC;

        // Both SYNC and STALL only re-anchor on a legal index; no period
        // exists yet because the previous strobe time is unknown or stale.
        SYNC, STALL: begin
          if (stepValidI) begin
            if (legal) begin
              prevStep <= stepI;
              cnt      <= CNT_ONE;
              stallO   <= 1'b0;
              state    <= MEASURE;
            end else begin
              seqErrO <= 1'b1;
            end
          end
        end

        MEASURE: begin
          if (stepValidI && (isFwd || isRev)) begin
            stepPeriodO  <= cnt;
            stepPeriodVO <= 1'b1;
            prevStep     <= stepI;
            cnt          <= CNT_ONE;
            if (isFwd != dirFwdO) begin
              // Reversal: this step is the first of a fresh round.
              dirFwdO  <= isFwd;
              acc      <= zext(cnt);
              roundCnt <= 4'd1;
            end else if (roundNext == ROUND_LAST) begin
              roundPeriodO <= accSum;
              roundValidO  <= 1'b1;
              acc          <= '0;
              roundCnt     <= '0;
            end else begin
              acc      <= accSum;
              roundCnt <= roundNext;
            end
          end else if (stepValidI) begin
            seqErrO  <= 1'b1;
            acc      <= '0;
            roundCnt <= '0;
            if (legal) begin
              prevStep <= stepI;
              cnt      <= CNT_ONE;
            end else begin
              // An out-of-range index is ignored for timing purposes.
              cnt <= satInc(cnt);
            end
          end else if (cnt == LIMIT) begin
            state    <= STALL;
            stallO   <= 1'b1;
            acc      <= '0;
            roundCnt <= '0;
          end else begin
            cnt <= satInc(cnt);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
